bus_dev_endpoint: RTL and testbench

- Device-side endpoint of the bus generator/arbiter protocol (pndng/pop/D_pop toward the bus, push/D_push from the bus); one instance per device port.
- Owns the per-device TX FIFO that the bus drains and the RX FIFO that the bus fills.
- RX side filters packets by destination ID (unicast to MY_ID or broadcast).
- Host side is a simple valid/ready write port and a pop-style read port.

---
 rtl/bus_ep_pkg.sv | 22 ++
 rtl/bus_ep_fifo.sv | 64 ++++++
 rtl/bus_dev_endpoint.sv | 140 ++++++++++++++
 tb/tb_bus_dev_endpoint.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_ep_pkg.sv
// bus_ep_pkg: shared types, field positions and helpers for the bus device endpoint.
//   pkt_t          default-width packet type
//   ID_MSB/ID_LSB  destination ID field position for the default packet geometry
//   BROADCAST_DEF  default broadcast destination ID
//   sat_inc16()    16-bit saturating increment used by the statistics counters
package bus_ep_pkg;

  localparam int unsigned PCKG_SZ_DEF = 32;
  localparam int unsigned BITS_DEF    = 8;
  localparam int unsigned ID_MSB      = PCKG_SZ_DEF - 1;
  localparam int unsigned ID_LSB      = PCKG_SZ_DEF - BITS_DEF;
  localparam int unsigned STAMP_W     = 32;

  localparam logic [BITS_DEF-1:0] BROADCAST_DEF = '1;

  typedef logic [PCKG_SZ_DEF-1:0] pkt_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/bus_ep_fifo.sv
// bus_ep_fifo: first-word fall-through FIFO with occupancy count.
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_wr_en, i_wr_data    write request; ignored while o_full (from the registered count)
//   i_rd_en, o_rd_data    read request; ignored while o_empty; o_rd_data shows the head
//   o_full, o_empty       registered-count status flags
//   o_count               occupancy, one bit wider than the pointers
module bus_ep_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_wr_en,
  input  logic [WIDTH-1:0]           i_wr_data,
  input  logic                       i_rd_en,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  // Full/empty come from the registered count only, so a same-cycle read
  // never makes room for a write.
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  assign w_wr = i_wr_en && !o_full;
  assign w_rd = i_rd_en && !o_empty;

  // Head is forced to zero while empty so the output is defined after reset.
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/bus_dev_endpoint.sv
// bus_dev_endpoint: device-side endpoint of the bus generator/arbiter protocol.
//   clk, reset             clock, asynchronous active-low reset
//   pndng, D_pop, pop      TX FIFO toward the bus (FWFT head, bus pops)
//   push, D_push           packets from the bus, filtered by destination ID
//   tx_valid/tx_data/tx_ready   host write port into TX FIFO
//   rx_valid/rx_data/rx_pop     host read port from RX FIFO (FWFT)
//   tx_count, rx_count     FIFO occupancies
//   misroute_cnt           saturating count of pushes with a foreign destination
//   rx_ovf_cnt             saturating count of matching pushes dropped on RX full
//   rx_stamp               (BUS_EP_RX_TIMESTAMP_EN only) push-cycle stamp aligned with rx_data
// Optional feature macro: BUS_EP_RX_TIMESTAMP_EN.
module bus_dev_endpoint
  import bus_ep_pkg::*;
#(
  parameter int unsigned    PCKG_SZ   = 32,
  parameter int unsigned    BITS      = 8,
  parameter int unsigned    MY_ID     = 0,
  parameter int unsigned    DEVS      = 5,
  parameter int unsigned    DEPTH     = 8,
  parameter logic [BITS-1:0] BROADCAST = {BITS{1'b1}}
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     pndng,
  output logic [PCKG_SZ-1:0]       D_pop,
  input  logic                     pop,
  input  logic                     push,
  input  logic [PCKG_SZ-1:0]       D_push,
  input  logic                     tx_valid,
  input  logic [PCKG_SZ-1:0]       tx_data,
  output logic                     tx_ready,
  output logic                     rx_valid,
  output logic [PCKG_SZ-1:0]       rx_data,
  input  logic                     rx_pop,
  output logic [$clog2(DEPTH):0]   tx_count,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic [15:0]              misroute_cnt,
`ifdef BUS_EP_RX_TIMESTAMP_EN
  output logic [STAMP_W-1:0]       rx_stamp,
`endif
  output logic [15:0]              rx_ovf_cnt
);

`ifdef BUS_EP_RX_TIMESTAMP_EN
  localparam int unsigned RX_W = PCKG_SZ + STAMP_W;
`else
  localparam int unsigned RX_W = PCKG_SZ;
`endif

  logic            w_tx_full;
  logic            w_tx_empty;
  logic            w_rx_full;
  logic            w_rx_empty;
  logic [BITS-1:0] w_dst;
  logic            w_match;
  logic            w_rx_wr;
  logic [RX_W-1:0] w_rx_wr_data;
  logic [RX_W-1:0] w_rx_rd_data;
  logic [15:0]     r_misroute_cnt;
  logic [15:0]     r_rx_ovf_cnt;

  // ---------------- TX path ----------------
  bus_ep_fifo #(
    .WIDTH (PCKG_SZ),
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .i_clk     (clk),
    .i_rst_n   (reset),
    .i_wr_en   (tx_valid),
    .i_wr_data (tx_data),
    .i_rd_en   (pop),
    .o_rd_data (D_pop),
    .o_full    (w_tx_full),
    .o_empty   (w_tx_empty),
    .o_count   (tx_count)
  );

  assign pndng    = !w_tx_empty;
  assign tx_ready = !w_tx_full;

  // ---------------- RX filter ----------------
  assign w_dst   = D_push[PCKG_SZ-1 -: BITS];
  assign w_match = (w_dst == BITS'(MY_ID)) || (w_dst == BROADCAST);
  assign w_rx_wr = push && w_match;

`ifdef BUS_EP_RX_TIMESTAMP_EN
  logic [STAMP_W-1:0] r_cycle;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_cycle <= '0;
    else        r_cycle <= r_cycle + 32'd1;
  end

  assign w_rx_wr_data = {r_cycle, D_push};
  assign rx_stamp     = w_rx_rd_data[RX_W-1 -: STAMP_W];
`else
  assign w_rx_wr_data = D_push;
`endif

  bus_ep_fifo #(
    .WIDTH (RX_W),
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .i_clk     (clk),
    .i_rst_n   (reset),
    .i_wr_en   (w_rx_wr),
    .i_wr_data (w_rx_wr_data),
    .i_rd_en   (rx_pop),
    .o_rd_data (w_rx_rd_data),
    .o_full    (w_rx_full),
    .o_empty   (w_rx_empty),
    .o_count   (rx_count)
  );

  assign rx_valid = !w_rx_empty;
  assign rx_data  = w_rx_rd_data[PCKG_SZ-1:0];

  // ---------------- Statistics ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_misroute_cnt <= '0;
      r_rx_ovf_cnt   <= '0;
    end else begin
      if (push && !w_match)           r_misroute_cnt <= sat_inc16(r_misroute_cnt);
      if (push && w_match && w_rx_full) r_rx_ovf_cnt <= sat_inc16(r_rx_ovf_cnt);
    end
  end

  assign misroute_cnt = r_misroute_cnt;
  assign rx_ovf_cnt   = r_rx_ovf_cnt;

`ifndef SYNTHESIS
  a_pop_empty : assert property (@(posedge clk) disable iff (!reset) pop |-> pndng)
    else $error("bus_dev_endpoint: pop while TX FIFO empty");
  a_cfg : assert property (@(posedge clk) disable iff (!reset)
    (MY_ID < DEVS) && (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0))
    else $error("bus_dev_endpoint: bad parameter configuration");
`endif

endmodule

// File: tb/tb_bus_dev_endpoint.sv
// tb_bus_dev_endpoint: directed stimulus with a queue scoreboard. Stimulus pushes the
// expected bus-side (D_pop) and host-side (rx_data) words; a monitor pops and compares
// whenever a pop handshake is presented. Define BUS_EP_RX_TIMESTAMP_EN to cover rx_stamp.
module tb_bus_dev_endpoint;
  import bus_ep_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        pndng;
  pkt_t        d_pop;
  logic        pop;
  logic        push;
  pkt_t        d_push;
  logic        tx_valid;
  pkt_t        tx_data;
  logic        tx_ready;
  logic        rx_valid;
  pkt_t        rx_data;
  logic        rx_pop;
  logic [3:0]  tx_count;
  logic [3:0]  rx_count;
  logic [15:0] misroute_cnt;
  logic [15:0] rx_ovf_cnt;
`ifdef BUS_EP_RX_TIMESTAMP_EN
  logic [31:0] rx_stamp;
`endif

  int n_vec = 0;
  int n_err = 0;
  pkt_t tx_q[$];
  pkt_t rx_q[$];

  always #5 clk = ~clk;

  bus_dev_endpoint #(
    .PCKG_SZ (32),
    .BITS    (8),
    .MY_ID   (2),
    .DEVS    (5),
    .DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pndng        (pndng),
    .D_pop        (d_pop),
    .pop          (pop),
    .push         (push),
    .D_push       (d_push),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_pop       (rx_pop),
    .tx_count     (tx_count),
    .rx_count     (rx_count),
    .misroute_cnt (misroute_cnt),
`ifdef BUS_EP_RX_TIMESTAMP_EN
    .rx_stamp     (rx_stamp),
`endif
    .rx_ovf_cnt   (rx_ovf_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the head of each FIFO against the scoreboard on every pop handshake.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (pop && pndng) begin
        if (tx_q.size() == 0) chk("tx_unexpected_pop", 64'(d_pop), 64'hDEAD);
        else                  chk("tx_order", 64'(d_pop), 64'(tx_q.pop_front()));
      end
      if (rx_pop && rx_valid) begin
        if (rx_q.size() == 0) chk("rx_unexpected_data", 64'(rx_data), 64'hDEAD);
        else                  chk("rx_order", 64'(rx_data), 64'(rx_q.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b0; pop = 1'b0; push = 1'b0; d_push = '0;
    tx_valid = 1'b0; tx_data = '0; rx_pop = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_pndng",    64'(pndng), 64'd0);
    chk("rst_tx_ready", 64'(tx_ready), 64'd1);
    chk("rst_rx_valid", 64'(rx_valid), 64'd0);
    chk("rst_tx_count", 64'(tx_count), 64'd0);
    chk("rst_rx_count", 64'(rx_count), 64'd0);
    chk("rst_d_pop",    64'(d_pop), 64'd0);
    chk("rst_rx_data",  64'(rx_data), 64'd0);
    chk("rst_misroute", 64'(misroute_cnt), 64'd0);
    chk("rst_ovf",      64'(rx_ovf_cnt), 64'd0);
    reset = 1'b1;
    step();

    // TX fill to 8, 9th ignored, drain in order
    for (int i = 1; i <= 8; i++) begin
      tx_valid = 1'b1; tx_data = pkt_t'(i);
      tx_q.push_back(pkt_t'(i));
      step();
      if (i == 1) chk("tx_first_pndng", 64'(pndng), 64'd1);
    end
    chk("tx_full_ready", 64'(tx_ready), 64'd0);
    tx_data = 32'h9;
    step();
    tx_valid = 1'b0;
    chk("tx_9th_ignored", 64'(tx_count), 64'd8);
    pop = 1'b1;
    repeat (8) step();
    pop = 1'b0;
    chk("tx_drained_pndng", 64'(pndng), 64'd0);
    chk("tx_drained_count", 64'(tx_count), 64'd0);

    // RX filter: unicast, broadcast, foreign
    push = 1'b1; d_push = 32'h02AB_CDEF; rx_q.push_back(32'h02AB_CDEF);
    step();
    chk("rx_uni_valid", 64'(rx_valid), 64'd1);
    chk("rx_uni_data",  64'(rx_data), 64'h02AB_CDEF);
    d_push = 32'hFF00_0011; rx_q.push_back(32'hFF00_0011);
    step();
    d_push = 32'h0300_0000;
    step();
    push = 1'b0;
    chk("rx_misroute", 64'(misroute_cnt), 64'd1);
    chk("rx_count2",   64'(rx_count), 64'd2);
    rx_pop = 1'b1;
    repeat (2) step();
    rx_pop = 1'b0;
    chk("rx_empty", 64'(rx_valid), 64'd0);

    // RX overflow with simultaneous rx_pop
    push = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d_push = 32'h0200_0000 + 32'(i);
      rx_q.push_back(32'h0200_0000 + 32'(i));
      step();
    end
    chk("rx_full_count", 64'(rx_count), 64'd8);
    d_push = 32'h0200_0099; rx_pop = 1'b1;
    step();
    push = 1'b0; rx_pop = 1'b0;
    chk("rx_ovf_cnt",   64'(rx_ovf_cnt), 64'd1);
    chk("rx_ovf_count", 64'(rx_count), 64'd7);
    chk("rx_ovf_misroute", 64'(misroute_cnt), 64'd1);
    rx_pop = 1'b1;
    repeat (7) step();
    rx_pop = 1'b0;
    chk("rx_drained", 64'(rx_count), 64'd0);

    // TX steady state: count 4, write+pop together for 10 cycles
    tx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tx_data = 32'h10 + 32'(i); tx_q.push_back(32'h10 + 32'(i));
      step();
    end
    pop = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tx_data = 32'h20 + 32'(k); tx_q.push_back(32'h20 + 32'(k));
      step();
      chk("tx_steady_count", 64'(tx_count), 64'd4);
    end
    tx_valid = 1'b0;
    repeat (4) step();
    pop = 1'b0;
    chk("tx_steady_empty", 64'(pndng), 64'd0);

    // Mid-operation reset with both FIFOs partly full
    tx_valid = 1'b1; tx_data = 32'hA1;
    repeat (3) step();
    tx_valid = 1'b0;
    push = 1'b1; d_push = 32'h0200_00B1;
    repeat (2) step();
    d_push = 32'h0400_0000;
    step();
    push = 1'b0;
    chk("pre_rst_tx_count", 64'(tx_count), 64'd3);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("mid_rst_pndng",    64'(pndng), 64'd0);
    chk("mid_rst_rx_valid", 64'(rx_valid), 64'd0);
    chk("mid_rst_tx_count", 64'(tx_count), 64'd0);
    chk("mid_rst_rx_count", 64'(rx_count), 64'd0);
    chk("mid_rst_misroute", 64'(misroute_cnt), 64'd0);
    chk("mid_rst_ovf",      64'(rx_ovf_cnt), 64'd0);

`ifdef BUS_EP_RX_TIMESTAMP_EN
    // Push sampled at the 101st edge after reset release carries stamp 100
    repeat (100) step();
    push = 1'b1; d_push = 32'hFF00_0100; rx_q.push_back(32'hFF00_0100);
    step();
    push = 1'b0;
    chk("rx_stamp", 64'(rx_stamp), 64'd100);
`else
    push = 1'b1; d_push = 32'h0200_0C01; rx_q.push_back(32'h0200_0C01);
    step();
    push = 1'b0;
`endif
    chk("post_rst_data", 64'(rx_data), 64'(rx_q[0]));
    rx_pop = 1'b1;
    step();
    rx_pop = 1'b0;

    chk("tx_scoreboard_empty", 64'(tx_q.size()), 64'd0);
    chk("rx_scoreboard_empty", 64'(rx_q.size()), 64'd0);
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
